micro_sequencer: RTL and testbench

Microprogram sequencer of the picoRISC hardwired-microcode control unit. It holds the microprogram counter (mPC) and publishes its one-hot decode `T[255:0]`. It consumes the branch-control outputs of the control-signal translation stage (`bropr`, `bradr`, `bruncnd`, `brcnd`, `signals`) and selects the next mPC each clock. It sits directly downstream of that translation stage, and its `T` output feeds back into it.

---
 rtl/mpc_pkg.sv | 21 ++
 rtl/micro_sequencer_branch_target_encoder.sv | 36 +++
 rtl/micro_sequencer.sv | 93 +++++++++
 tb/tb_micro_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpc_pkg.sv
// rtl/mpc_pkg.sv - shared widths, dispatch targets and select-field positions for the microprogram sequencer
package mpc_pkg;

    localparam int MPC_W = 8;
    localparam int SIG_W = 16;

    localparam int MPC_TGT0 = 0;
    localparam int MPC_TGT1 = 9;
    localparam int MPC_TGT2 = 17;
    localparam int MPC_TGT3 = 19;
    localparam int MPC_TGT4 = 41;
    localparam int MPC_TGT5 = 49;

    // signals[SIG_SEL_HI] selects MPC_TGT0, descending to signals[SIG_SEL_LO] for MPC_TGT5
    localparam int SIG_SEL_HI = 15;
    localparam int SIG_SEL_LO = 10;
    localparam int SIG_SEL_N  = SIG_SEL_HI - SIG_SEL_LO + 1;

    typedef logic [MPC_W-1:0] mpc_t;

endpackage

// File: rtl/micro_sequencer_branch_target_encoder.sv
// rtl/micro_sequencer_branch_target_encoder.sv - maps the one-hot signals select field to a microprogram target
module branch_target_encoder
    import mpc_pkg::*;
#(
    parameter int TGT_W = mpc_pkg::MPC_W
) (
    input  logic [SIG_SEL_N-1:0] sel_i,
    output logic [TGT_W-1:0]     target_o,
    output logic                 valid_o,
    output logic                 multi_o
);

    // Highest-order select bit wins when several are set
    always_comb begin
        target_o = '0;
        valid_o  = 1'b1;
        if (sel_i[5]) begin
            target_o = TGT_W'(MPC_TGT0);
        end else if (sel_i[4]) begin
            target_o = TGT_W'(MPC_TGT1);
        end else if (sel_i[3]) begin
            target_o = TGT_W'(MPC_TGT2);
        end else if (sel_i[2]) begin
            target_o = TGT_W'(MPC_TGT3);
        end else if (sel_i[1]) begin
            target_o = TGT_W'(MPC_TGT4);
        end else if (sel_i[0]) begin
            target_o = TGT_W'(MPC_TGT5);
        end else begin
            valid_o = 1'b0;
        end
    end

    assign multi_o = |(sel_i & (sel_i - SIG_SEL_N'(1)));

endmodule

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - microprogram counter with priority next-address select and registered one-hot decode
module micro_sequencer
    import mpc_pkg::*;
#(
    parameter int MPC_W = mpc_pkg::MPC_W,
    parameter int SIG_W = mpc_pkg::SIG_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  bropr,
    input  logic                  bradr,
    input  logic                  bruncnd,
    input  logic                  brcnd,
    input  logic [SIG_W-1:0]      signals,
    input  logic [MPC_W-1:0]      mopr_addr,
    input  logic [MPC_W-1:0]      madr_addr,
    output logic [MPC_W-1:0]      mpc,
    output logic [(2**MPC_W)-1:0] T,
    output logic                  seq_err
);

    localparam int T_W = 2 ** MPC_W;

    logic [MPC_W-1:0] mpc_q, mpc_d;
    logic [T_W-1:0]   T_q, T_d;
    logic             seq_err_q, seq_err_d;

    logic [MPC_W-1:0] enc_target;
    logic             enc_valid;
    logic             enc_multi;
    logic             sig_br;
    logic             multi_src;
    logic             unused_sig;

    assign unused_sig = ^signals[SIG_SEL_LO-1:0];

    branch_target_encoder #(
        .TGT_W (MPC_W)
    ) u_encoder (
        .sel_i    (signals[SIG_SEL_HI:SIG_SEL_LO]),
        .target_o (enc_target),
        .valid_o  (enc_valid),
        .multi_o  (enc_multi)
    );

    assign sig_br    = bruncnd | brcnd;
    assign multi_src = (bropr & bradr) | (bropr & sig_br) | (bradr & sig_br);

    always_comb begin
        mpc_d     = mpc_q + MPC_W'(1);
        seq_err_d = seq_err_q;
        if (!hold) begin
            if (multi_src) begin
                seq_err_d = 1'b1;
            end
            if (bropr) begin
                mpc_d = mopr_addr;
            end else if (bradr) begin
                mpc_d = madr_addr;
            end else if (sig_br) begin
                // An empty select falls through to mpc+1 but is still flagged
                if (enc_valid) begin
                    mpc_d = enc_target;
                end
                if (!enc_valid || enc_multi) begin
                    seq_err_d = 1'b1;
                end
            end
        end else begin
            mpc_d = mpc_q;
        end
    end

    assign T_d = {{(T_W-1){1'b0}}, 1'b1} << mpc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mpc_q     <= '0;
            T_q       <= {{(T_W-1){1'b0}}, 1'b1};
            seq_err_q <= 1'b0;
        end else if (!hold) begin
            mpc_q     <= mpc_d;
            T_q       <= T_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign mpc     = mpc_q;
    assign T       = T_q;
    assign seq_err = seq_err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - randomized self-checking bench for micro_sequencer against a behavioural model
module tb_micro_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         hold;
    logic         bropr;
    logic         bradr;
    logic         bruncnd;
    logic         brcnd;
    logic [15:0]  signals;
    logic [7:0]   mopr_addr;
    logic [7:0]   madr_addr;
    logic [7:0]   mpc;
    logic [255:0] T;
    logic         seq_err;

    int vectors = 0;
    int miscompares = 0;

    int exp_mpc;
    bit exp_err;
    int tgt_tbl [6] = '{0, 9, 17, 19, 41, 49};

    micro_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .bropr     (bropr),
        .bradr     (bradr),
        .bruncnd   (bruncnd),
        .brcnd     (brcnd),
        .signals   (signals),
        .mopr_addr (mopr_addr),
        .madr_addr (madr_addr),
        .mpc       (mpc),
        .T         (T),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] exp_t(input int m);
        logic [255:0] v;
        v = '0;
        v[m] = 1'b1;
        return v;
    endfunction

    function automatic void model_step();
        int srcs;
        int nsel;
        bit found;
        if (hold) return;
        srcs = int'(bropr) + int'(bradr) + int'(bruncnd | brcnd);
        if (srcs > 1) exp_err = 1'b1;
        if (bropr) begin
            exp_mpc = mopr_addr;
        end else if (bradr) begin
            exp_mpc = madr_addr;
        end else if (bruncnd | brcnd) begin
            nsel = $countones(signals[15:10]);
            if (nsel == 0) begin
                exp_mpc = (exp_mpc + 1) % 256;
                exp_err = 1'b1;
            end else begin
                found = 1'b0;
                for (int b = 15; b >= 10; b--) begin
                    if (signals[b] && !found) begin
                        exp_mpc = tgt_tbl[15 - b];
                        found = 1'b1;
                    end
                end
                if (nsel > 1) exp_err = 1'b1;
            end
        end else begin
            exp_mpc = (exp_mpc + 1) % 256;
        end
    endfunction

    task automatic idle_inputs();
        hold = 0; bropr = 0; bradr = 0; bruncnd = 0; brcnd = 0;
        signals = 16'h0; mopr_addr = 8'h0; madr_addr = 8'h0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_mpc = 0;
        exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #12;
        vectors++;
        if (mpc !== 8'd0) begin
            miscompares++; $display("FAIL reset_mpc: got %0d want 0", mpc);
        end
        vectors++;
        if (T !== exp_t(0)) begin
            miscompares++; $display("FAIL reset_T: got %h want %h", T, exp_t(0));
        end
        vectors++;
        if (seq_err !== 1'b0) begin
            miscompares++; $display("FAIL reset_err: got %0b want 0", seq_err);
        end
        exp_mpc = 0;
        exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle();
        for (int k = 1; k <= 4; k++) begin
            tick();
            vectors++;
            if (mpc !== 8'(k)) begin
                miscompares++; $display("FAIL idle_mpc: got %0d want %0d", mpc, k);
            end
            vectors++;
            if (T !== exp_t(k)) begin
                miscompares++; $display("FAIL idle_T: got %h want %h", T, exp_t(k));
            end
            vectors++;
            if (seq_err !== 1'b0) begin
                miscompares++; $display("FAIL idle_err: got %0b want 0", seq_err);
            end
        end
    endtask

    task automatic test_signals_branch();
        brcnd = 1'b1; signals = 16'h4000;
        tick();
        vectors++;
        if (mpc !== 8'd9 || T !== exp_t(9)) begin
            miscompares++; $display("FAIL brcnd_tgt: got %0d want 9", mpc);
        end
        brcnd = 1'b0; bruncnd = 1'b1; signals = 16'h0400;
        tick();
        vectors++;
        if (mpc !== 8'd49 || T !== exp_t(49)) begin
            miscompares++; $display("FAIL bruncnd_tgt: got %0d want 49", mpc);
        end
        vectors++;
        if (seq_err !== 1'b0) begin
            miscompares++; $display("FAIL branch_err: got %0b want 0", seq_err);
        end
        idle_inputs();
    endtask

    task automatic test_multi_source();
        bropr = 1'b1; mopr_addr = 8'h60; bradr = 1'b1; madr_addr = 8'h33;
        tick();
        vectors++;
        if (mpc !== 8'h60 || T !== exp_t(8'h60)) begin
            miscompares++; $display("FAIL multi_src_mpc: got %0h want 60", mpc);
        end
        vectors++;
        if (seq_err !== 1'b1) begin
            miscompares++; $display("FAIL multi_src_err: got %0b want 1", seq_err);
        end
        idle_inputs();
    endtask

    task automatic test_hold();
        hold = 1'b1; bruncnd = 1'b1; signals = 16'h2000;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (mpc !== 8'h60 || T !== exp_t(8'h60)) begin
                miscompares++; $display("FAIL hold_frozen: got %0h want 60", mpc);
            end
        end
        hold = 1'b0;
        tick();
        vectors++;
        if (mpc !== 8'd17 || T !== exp_t(17)) begin
            miscompares++; $display("FAIL hold_release: got %0d want 17", mpc);
        end
        idle_inputs();
    endtask

    task automatic test_wrap_and_multi_select();
        do_reset();
        bradr = 1'b1; madr_addr = 8'hFF;
        tick();
        vectors++;
        if (mpc !== 8'hFF || T !== exp_t(255)) begin
            miscompares++; $display("FAIL force_255: got %0d want 255", mpc);
        end
        idle_inputs();
        tick();
        vectors++;
        if (mpc !== 8'd0 || T !== exp_t(0)) begin
            miscompares++; $display("FAIL wrap_mpc: got %0d want 0", mpc);
        end
        vectors++;
        if (seq_err !== 1'b0) begin
            miscompares++; $display("FAIL wrap_err: got %0b want 0", seq_err);
        end
        brcnd = 1'b1; signals = 16'hC000;
        tick();
        vectors++;
        if (mpc !== 8'd0 || T !== exp_t(0)) begin
            miscompares++; $display("FAIL multi_sel_mpc: got %0d want 0", mpc);
        end
        vectors++;
        if (seq_err !== 1'b1) begin
            miscompares++; $display("FAIL multi_sel_err: got %0b want 1", seq_err);
        end
        brcnd = 1'b1; signals = 16'h0000;
        tick();
        vectors++;
        if (mpc !== 8'd1 || seq_err !== 1'b1) begin
            miscompares++; $display("FAIL empty_sel: got mpc %0d err %0b want 1/1", mpc, seq_err);
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        bruncnd = 1'b1; signals = 16'h0800;
        tick();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        exp_mpc = 0;
        exp_err = 1'b0;
        vectors++;
        if (mpc !== 8'd0 || T !== exp_t(0) || seq_err !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got mpc %0d err %0b want 0/0", mpc, seq_err);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (mpc !== 8'd0 || T !== exp_t(0)) begin
            miscompares++; $display("FAIL reset_held: got %0d want 0", mpc);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        tick();
        vectors++;
        if (mpc !== 8'd1 || seq_err !== 1'b0) begin
            miscompares++; $display("FAIL post_reset: got mpc %0d err %0b want 1/0", mpc, seq_err);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            hold      = ($urandom_range(0, 9) < 2);
            bropr     = ($urandom_range(0, 9) == 0);
            bradr     = ($urandom_range(0, 9) == 0);
            bruncnd   = ($urandom_range(0, 7) == 0);
            brcnd     = ($urandom_range(0, 5) == 0);
            mopr_addr = 8'($urandom);
            madr_addr = 8'($urandom);
            signals   = 16'($urandom) & 16'h03FF;
            case ($urandom_range(0, 3))
                0: signals = signals;
                1, 2: signals[10 + $urandom_range(0, 5)] = 1'b1;
                default: signals[15:10] = 6'($urandom);
            endcase
            if (i % 97 == 96) do_reset();
            tick();
            vectors++;
            if (mpc !== 8'(exp_mpc) || T !== exp_t(exp_mpc)) begin
                miscompares++; $display("FAIL rand_mpc[%0d]: got %0d want %0d", i, mpc, exp_mpc);
            end
            vectors++;
            if (seq_err !== exp_err) begin
                miscompares++; $display("FAIL rand_err[%0d]: got %0b want %0b", i, seq_err, exp_err);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_idle();
        test_signals_branch();
        test_multi_source();
        test_hold();
        test_wrap_and_multi_select();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
